// File: rtl/dice_roller.sv
// Dice source for the game core: uniform 1..6 rolls from a 16-bit LFSR with
// bounded rejection sampling, valid/ready output and six-streak flags.
module dice_roller #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned AUTO_PERIOD = 8,
  parameter int unsigned MAX_TRIES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        roll_req,
  input  logic        auto_en,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        dice_ready,
  output logic        dice_valid,
  output logic [2:0]  dice_val,
  output logic        extra_turn,
  output logic        triple_six,
  output logic        busy,
  output logic [7:0]  roll_count
);

  localparam int unsigned AW = $clog2(AUTO_PERIOD + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_t;

  state_t        state, state_nxt;
  logic [15:0]   lfsr;
  logic          fb;
  logic [AW-1:0] auto_cnt;
  logic [TW-1:0] try_cnt;
  logic [1:0]    streak;
  logic [2:0]    cand;
  logic [2:0]    roll_val;
  logic          cand_ok;
  logic          start;
  logic          latch;
  logic          accept;

  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand    = lfsr[2:0];
  assign cand_ok = (cand != 3'd0) && (cand != 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    latch     = 1'b0;
    accept    = 1'b0;
    roll_val  = cand;
    case (state)
      IDLE: begin
        if (roll_req || (auto_en && auto_cnt == AUTO_LAST)) begin
          start     = 1'b1;
          state_nxt = ROLL;
        end
      end
      ROLL: begin
        if (cand_ok) begin
          latch     = 1'b1;
          state_nxt = HOLD;
        end else if (try_cnt == TRY_LAST) begin
          // Out of draws: map the rejected candidate onto a fixed face.
          latch     = 1'b1;
          roll_val  = (cand == 3'd0) ? 3'd1 : 3'd2;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (dice_ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= SEED;
      auto_cnt   <= '0;
      try_cnt    <= '0;
      streak     <= '0;
      dice_val   <= '0;
      triple_six <= 1'b0;
      roll_count <= '0;
    end else begin
      if (seed_load) lfsr <= (seed == '0) ? SEED : seed;
      else           lfsr <= {lfsr[14:0], fb};

      // Held at zero outside IDLE so every IDLE entry starts a fresh period.
      if (state == IDLE && auto_en && !start) auto_cnt <= auto_cnt + 1'b1;
      else                                     auto_cnt <= '0;

      if (state == ROLL && !latch) try_cnt <= try_cnt + 1'b1;
      else                         try_cnt <= '0;

      if (latch) begin
        dice_val <= roll_val;
        if (roll_val == 3'd6) begin
          if (streak == 2'd2) begin
            triple_six <= 1'b1;
            streak     <= '0;
          end else begin
            triple_six <= 1'b0;
            streak     <= streak + 1'b1;
          end
        end else begin
          triple_six <= 1'b0;
          streak     <= '0;
        end
      end

      if (accept) roll_count <= roll_count + 1'b1;
    end
  end

  assign dice_valid = (state == HOLD);
  assign busy       = (state != IDLE);
  assign extra_turn = dice_valid && (dice_val == 3'd6);

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: expected rolls are queued when a roll
// is started and compared when the handshake completes.
module tb_dice_roller;

  localparam int MAX_T = 4;

  logic        clk;
  logic        reset;
  logic        roll_req;
  logic        auto_en;
  logic        seed_load;
  logic [15:0] seed;
  logic        dice_ready;
  logic        dice_valid;
  logic [2:0]  dice_val;
  logic        extra_turn;
  logic        triple_six;
  logic        busy;
  logic [7:0]  roll_count;

  typedef struct {
    logic [2:0] val;
    logic       six;
    logic       triple;
  } roll_t;

  roll_t       q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          streak_m = 0;
  logic [15:0] m;
  logic [7:0]  exp_count = '0;
  logic        mon_en = 1'b0;

  dice_roller #(
    .SEED        (16'hACE1),
    .AUTO_PERIOD (8),
    .MAX_TRIES   (MAX_T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .roll_req   (roll_req),
    .auto_en    (auto_en),
    .seed_load  (seed_load),
    .seed       (seed),
    .dice_ready (dice_ready),
    .dice_valid (dice_valid),
    .dice_val   (dice_val),
    .extra_turn (extra_turn),
    .triple_six (triple_six),
    .busy       (busy),
    .roll_count (roll_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Shadow LFSR driven from the same inputs as the DUT.
  always @(posedge clk) begin
    if (reset)          m <= 16'hACE1;
    else if (seed_load) m <= (seed == 16'h0) ? 16'hACE1 : seed;
    else                m <= lstep(m);
  end

  // Scoreboard: compare at the handshake, track the expected roll count.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("roll_count", {24'h0, roll_count}, {24'h0, exp_count});
      if (reset) begin
        exp_count <= '0;
      end else if (dice_valid && dice_ready) begin
        chk("pending_roll", {31'h0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          roll_t r;
          r = q.pop_front();
          chk("dice_val",   {29'h0, dice_val},   {29'h0, r.val});
          chk("extra_turn", {31'h0, extra_turn}, {31'h0, r.six});
          chk("triple_six", {31'h0, triple_six}, {31'h0, r.triple});
        end
        exp_count <= exp_count + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] v);
    roll_t r;
    r.val = v;
    r.six = (v == 3'd6);
    r.triple = 1'b0;
    if (v == 3'd6) begin
      if (streak_m == 2) begin
        r.triple = 1'b1;
        streak_m = 0;
      end else begin
        streak_m++;
      end
    end else begin
      streak_m = 0;
    end
    q.push_back(r);
  endtask

  task automatic predict(input logic [15:0] l0, output logic [2:0] v, output int k);
    logic [15:0] l;
    logic [2:0]  c;
    l = l0;
    v = 3'd0;
    k = 0;
    for (int i = 0; i < MAX_T; i++) begin
      c = l[2:0];
      if (c != 3'd0 && c != 3'd7) begin
        v = c;
        k = i;
        return;
      end
      if (i == MAX_T - 1) begin
        v = (c == 3'd0) ? 3'd1 : 3'd2;
        k = i;
        return;
      end
      l = lstep(l);
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("roll_done_in_time", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] v;
    int         k;
    logic [7:0] cnt_before;
    logic [2:0] six_triples [4];
    six_triples[0] = 3'd0; six_triples[1] = 3'd0; six_triples[2] = 3'd1; six_triples[3] = 3'd0;

    reset = 1'b1; roll_req = 1'b0; auto_en = 1'b0; seed_load = 1'b0;
    seed = 16'h0; dice_ready = 1'b0;
    tick(); tick();
    chk("rst_valid",  {31'h0, dice_valid}, 32'd0);
    chk("rst_val",    {29'h0, dice_val},   32'd0);
    chk("rst_extra",  {31'h0, extra_turn}, 32'd0);
    chk("rst_triple", {31'h0, triple_six}, 32'd0);
    chk("rst_busy",   {31'h0, busy},       32'd0);
    chk("rst_count",  {24'h0, roll_count}, 32'd0);
    chk("rst_lfsr",   {16'h0, dut.lfsr},   32'h0000ACE1);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_no_roll", {31'h0, dice_valid}, 32'd0);
    end

    // Seed 2: first candidate 4 is accepted.
    dice_ready = 1'b1;
    seed_load = 1'b1; seed = 16'h0002; tick();
    seed_load = 1'b0; roll_req = 1'b1; push_exp(3'd4); tick();
    roll_req = 1'b0; tick();
    chk("seed2_valid", {31'h0, dice_valid}, 32'd1);
    chk("seed2_val",   {29'h0, dice_val},   32'd4);
    tick();
    chk("seed2_drop",  {31'h0, dice_valid}, 32'd0);
    chk("seed2_count", {24'h0, roll_count}, 32'd1);

    // Seed 4: four rejected zeros, forced face 1.
    seed_load = 1'b1; seed = 16'h0004; tick();
    seed_load = 1'b0; roll_req = 1'b1; push_exp(3'd1); tick();
    roll_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("forced_wait", {31'h0, dice_valid}, 32'd0);
    end
    tick();
    chk("forced_valid", {31'h0, dice_valid}, 32'd1);
    chk("forced_val",   {29'h0, dice_val},   32'd1);
    tick();

    // Four consecutive sixes: triple flag only on the third.
    for (int r = 0; r < 4; r++) begin
      seed_load = 1'b1; seed = 16'h0003; tick();
      seed_load = 1'b0; roll_req = 1'b1; push_exp(3'd6); tick();
      roll_req = 1'b0; tick();
      chk("six_val",    {29'h0, dice_val},   32'd6);
      chk("six_extra",  {31'h0, extra_turn}, 32'd1);
      chk("six_triple", {31'h0, triple_six}, {29'h0, six_triples[r]});
      tick();
    end

    // Consumer stalls in HOLD while roll_req is pulsed.
    dice_ready = 1'b0;
    seed_load = 1'b1; seed = 16'h0002; tick();
    seed_load = 1'b0; roll_req = 1'b1; push_exp(3'd4); tick();
    roll_req = 1'b0; tick();
    cnt_before = exp_count;
    for (int i = 0; i < 10; i++) begin
      roll_req = (i % 2 == 0);
      tick();
      chk("stall_valid", {31'h0, dice_valid}, 32'd1);
      chk("stall_val",   {29'h0, dice_val},   32'd4);
    end
    roll_req = 1'b0; dice_ready = 1'b1; tick();
    chk("stall_drop",  {31'h0, dice_valid}, 32'd0);
    chk("stall_count", {24'h0, roll_count}, {24'h0, cnt_before + 8'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_requeue", {31'h0, busy}, 32'd0);
    end

    // Auto rolls every 8 IDLE cycles; the fourth is cut by reset in HOLD.
    auto_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) tick();
      chk("auto_wait",  {31'h0, busy}, 32'd0);
      tick();
      chk("auto_start", {31'h0, busy}, 32'd1);
      predict(m, v, k);
      push_exp(v);
      if (r == 3) dice_ready = 1'b0;
      repeat (1 + k) tick();
      chk("auto_hold", {31'h0, dice_valid}, 32'd1);
      if (r < 3) begin
        tick();
        chk("auto_drop", {31'h0, dice_valid}, 32'd0);
      end
    end
    reset = 1'b1;
    q.delete();
    streak_m = 0;
    tick();
    chk("midhold_valid", {31'h0, dice_valid}, 32'd0);
    chk("midhold_busy",  {31'h0, busy},       32'd0);
    chk("midhold_count", {24'h0, roll_count}, 32'd0);
    chk("midhold_val",   {29'h0, dice_val},   32'd0);
    reset = 1'b0; auto_en = 1'b0;
    tick(); tick(); tick();
    wait_idle();
    chk("queue_drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
